sprite_pixel_fetcher: RTL and testbench
=======================================

# sprite_pixel_fetcher

Reads one 20x20, 8-bit sprite from a synchronous-read sprite ROM (one-cycle read latency, such as the digit/number ROMs) and overlays it on the VGA pixel stream. For each scan position it checks whether the pixel lies inside the sprite box and generates the ROM address. It pipelines the in-box flag so that it lines up with the returned ROM data, then emits a registered pixel colour plus a hit flag for the colour mux. One instance is used per on-screen sprite: score digits, tile glyphs.

## Interface
- SPR_W, 20, sprite width in pixels
- SPR_H, 20, sprite height in pixels
- ADDR_W, 10, ROM address width
- DATA_W, 8, pixel width
- COORD_W, 10, screen coordinate width
- TRANSPARENT, 8'h00, colour key treated as "no pixel"

Ports:
- i_clk  in  1  pixel clock, the same clock that drives the ROM
- i_rst_n  in  1  reset: asynchronous, active-low
- i_x  in  COORD_W  current scan column
- i_y  in  COORD_W  current scan row
- i_active  in  1  visible-area flag for i_x/i_y
- i_frame_start  in  1  one-cycle pulse at the start of each frame
- i_pos_x  in  COORD_W  sprite top-left column; sampled only on i_frame_start
- i_pos_y  in  COORD_W  sprite top-left row; sampled only on i_frame_start
- i_enable  in  1  sprite visible; sampled only on i_frame_start
- o_numberaddr  out  ADDR_W  ROM address, registered
- i_numberdata  in  DATA_W  ROM data, returned one cycle after the address
- o_pixel  out  DATA_W  sprite colour, registered
- o_hit  out  1  sprite pixel present and opaque, registered

## Operation
- **Frame latch.** On an edge where i_frame_start=1, the block loads i_pos_x, i_pos_y and i_enable into pos_x_q, pos_y_q and en_q. Otherwise these registers hold. Reset values: 0, 0, 0.
- **In-box test.** in_box = en_q & i_active & (i_x >= pos_x_q) & (i_x < pos_x_q+SPR_W) & (i_y >= pos_y_q) & (i_y < pos_y_q+SPR_H).
  - Both sums are computed in COORD_W+1 bits so they never wrap.
  - A sprite that runs past the right or bottom screen edge is clipped, never wrapped.
- **Address.**
  - dx = i_x - pos_x_q and dy = i_y - pos_y_q, each 5 bits wide.
  - addr = dy*SPR_W + dx, computed as (dy<<4)+(dy<<2)+dx for SPR_W=20, with no multiplier.
  - The result lies in 0..399.
  - When in_box=0, the registered address is forced to 0.
- **Pipeline.**
  - S1: register o_numberaddr and hit_s1 <= in_box.
  - S2: the ROM registers its data, and hit_s2 <= hit_s1 in parallel.
  - S3: o_pixel <= hit_s2 ? i_numberdata : 0, and o_hit <= hit_s2 & (i_numberdata != TRANSPARENT).
- **Same-cycle frame start.** If i_frame_start coincides with a pixel, that pixel is evaluated with the old latched values. The new values apply from the next cycle.
- **Reset.** Asserting i_rst_n=0 at any time, including mid-line, immediately clears all pipeline flags, o_numberaddr, o_pixel, o_hit and the latched registers. No stale hit may appear after reset is released.

## Timing
- Latency from i_x/i_y to o_pixel/o_hit: 3 cycles, fixed. The VGA colour path must delay its own signals by 3 cycles to match.
- Throughput: one pixel per clock. No stalls, no handshake.
- o_numberaddr updates 1 cycle after the inputs. i_numberdata is expected 1 cycle after o_numberaddr.
- Reset values: o_numberaddr=0, o_pixel=0, o_hit=0, hit_s1=0, hit_s2=0, pos_x_q=0, pos_y_q=0, en_q=0.
- Back-to-back frames: a pulse on every i_frame_start is legal. Sprite position changes only take effect at frame boundaries, so there is no tearing.

## Structure
- Shared package sprite_pkg holds SPR_W, SPR_H, ADDR_W, DATA_W, COORD_W and TRANSPARENT. The ROM modules and the fetchers all size themselves from it.
- One sub-module, sprite_bbox: the combinational in-box test plus dx/dy. It is reused by the tile-collision logic.
- The ROM is instantiated outside this block. o_numberaddr and i_numberdata connect straight to the ROM ports.

## Test plan
1. **Basic fetch.** Reset, then frame_start with pos=(100,50), enable=1. Scan (103,52) with active=1.
   - o_numberaddr=43 one cycle later.
   - With a ROM model returning 8'hA5: o_pixel=8'hA5 and o_hit=1 exactly 3 cycles after the input.
2. **Box corners.** pos=(100,50).
   - (100,50) gives addr 0; (119,69) gives addr 399. Both hit.
   - (120,50), (99,50) and (100,70) give hit=0, o_pixel=0, addr=0.
3. **Transparency.** A ROM word of 8'h00 inside the box gives o_pixel=0 and o_hit=0. Word 8'h01 gives o_hit=1.
4. **Clipping.** pos=(630,470) on a 640x480 raster. Only x 630..639 and y 470..479 hit. Nothing hits at x=0 or y=0.
5. **Frame latch.** Change i_pos_x to 200 mid-frame without a frame_start: the hit region is unchanged. After frame_start, hits move to x 200..219. With enable=0 latched, there are no hits anywhere.
6. **Reset mid-line.** Pulse i_rst_n low while hit_s1/hit_s2 are 1.
   - All outputs go to 0 asynchronously.
   - After release, there is no hit until the next frame_start with enable=1.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite geometry and pixel format, used by the sprite ROMs, fetchers and the tile-collision logic.
package sprite_pkg;
    localparam int SPR_W   = 20;
    localparam int SPR_H   = 20;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int COORD_W = 10;
    localparam logic [DATA_W-1:0] TRANSPARENT = 8'h00;

    // dy*20 + dx built from shifts: dy*16 + dy*4 + dx, at most 399.
    function automatic logic [ADDR_W-1:0] spr_addr(input logic [4:0] dy, input logic [4:0] dx);
        return {1'b0, dy, 4'b0000} + {3'b000, dy, 2'b00} + {5'b00000, dx};
    endfunction
endpackage

// File: rtl/sprite_bbox.sv
// Combinational sprite bounding-box test plus the sprite-relative offsets dx/dy.
module sprite_bbox
    import sprite_pkg::*;
(
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  logic               i_en,
    input  logic               i_active,
    output logic               o_in_box,
    output logic [4:0]         o_dx,
    output logic [4:0]         o_dy
);
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;

    // One extra bit on the far edges so a sprite near the screen edge clips instead of wrapping.
    always_comb begin
        x_end    = {1'b0, i_pos_x} + (COORD_W+1)'(SPR_W);
        y_end    = {1'b0, i_pos_y} + (COORD_W+1)'(SPR_H);
        o_in_box = i_en & i_active
                 & (i_x >= i_pos_x) & ({1'b0, i_x} < x_end)
                 & (i_y >= i_pos_y) & ({1'b0, i_y} < y_end);
        o_dx     = i_x[4:0] - i_pos_x[4:0];
        o_dy     = i_y[4:0] - i_pos_y[4:0];
    end
endmodule

// File: rtl/sprite_pixel_fetcher.sv
// Overlays one 20x20 sprite on the scan stream: box test, ROM address, and a 3-cycle aligned colour/hit.
module sprite_pixel_fetcher
    import sprite_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic               i_active,
    input  logic               i_frame_start,
    input  logic [COORD_W-1:0] i_pos_x,
    input  logic [COORD_W-1:0] i_pos_y,
    input  logic               i_enable,
    output logic [ADDR_W-1:0]  o_numberaddr,
    input  logic [DATA_W-1:0]  i_numberdata,
    output logic [DATA_W-1:0]  o_pixel,
    output logic               o_hit
);
    logic [COORD_W-1:0] pos_x_q, pos_x_d;
    logic [COORD_W-1:0] pos_y_q, pos_y_d;
    logic               en_q, en_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               hit_s1_q, hit_s1_d;
    logic               hit_s2_q, hit_s2_d;
    logic [DATA_W-1:0]  pixel_q, pixel_d;
    logic               hit_q, hit_d;

    logic       in_box;
    logic [4:0] dx;
    logic [4:0] dy;

    // The current pixel is tested against the old latch even when frame_start coincides with it.
    sprite_bbox u_bbox (
        .i_x      (i_x),
        .i_y      (i_y),
        .i_pos_x  (pos_x_q),
        .i_pos_y  (pos_y_q),
        .i_en     (en_q),
        .i_active (i_active),
        .o_in_box (in_box),
        .o_dx     (dx),
        .o_dy     (dy)
    );

    always_comb begin
        pos_x_d  = i_frame_start ? i_pos_x  : pos_x_q;
        pos_y_d  = i_frame_start ? i_pos_y  : pos_y_q;
        en_d     = i_frame_start ? i_enable : en_q;
        addr_d   = in_box ? spr_addr(dy, dx) : '0;
        hit_s1_d = in_box;
        hit_s2_d = hit_s1_q;
        // i_numberdata is the ROM word for the address issued two edges ago, aligned with hit_s2.
        pixel_d  = hit_s2_q ? i_numberdata : '0;
        hit_d    = hit_s2_q & (i_numberdata != TRANSPARENT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pos_x_q  <= '0;
            pos_y_q  <= '0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            hit_s1_q <= 1'b0;
            hit_s2_q <= 1'b0;
            pixel_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            hit_s1_q <= hit_s1_d;
            hit_s2_q <= hit_s2_d;
            pixel_q  <= pixel_d;
            hit_q    <= hit_d;
        end
    end

    assign o_numberaddr = addr_q;
    assign o_pixel      = pixel_q;
    assign o_hit        = hit_q;
endmodule

// File: tb/tb_sprite_pixel_fetcher.sv
// Bench for sprite_pixel_fetcher: ROM model plus a per-pixel reference of the sprite overlay.
module tb_sprite_pixel_fetcher;
    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [9:0] i_x, i_y, i_pos_x, i_pos_y;
    logic       i_active, i_frame_start, i_enable;
    logic [9:0] o_numberaddr;
    logic [7:0] i_numberdata;
    logic [7:0] o_pixel;
    logic       o_hit;

    sprite_pixel_fetcher dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_x           (i_x),
        .i_y           (i_y),
        .i_active      (i_active),
        .i_frame_start (i_frame_start),
        .i_pos_x       (i_pos_x),
        .i_pos_y       (i_pos_y),
        .i_enable      (i_enable),
        .o_numberaddr  (o_numberaddr),
        .i_numberdata  (i_numberdata),
        .o_pixel       (o_pixel),
        .o_hit         (o_hit)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] rom [0:1023];
    logic [7:0] rom_q;
    always @(posedge i_clk) rom_q <= rom[o_numberaddr];
    assign i_numberdata = rom_q;

    int checks = 0;
    int errors = 0;

    int  px_m, py_m;
    bit  en_m;
    int  a1;
    logic [7:0] p1, p2, p3;
    bit  h1, h2, h3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic clear_model();
        px_m = 0; py_m = 0; en_m = 0;
        a1 = 0; p1 = 0; p2 = 0; p3 = 0; h1 = 0; h2 = 0; h3 = 0;
    endtask

    // One scan pixel: check outputs owed by earlier pixels, then drive and predict this one.
    task automatic cycle(input int x, input int y, input bit act, input bit fs,
                         input int npx, input int npy, input bit nen);
        bit hit;
        int a;
        @(negedge i_clk);
        chk("addr",  o_numberaddr, a1);
        chk("pixel", o_pixel, p3);
        chk("hit",   o_hit, h3);
        i_x = x[9:0]; i_y = y[9:0]; i_active = act; i_frame_start = fs;
        i_pos_x = npx[9:0]; i_pos_y = npy[9:0]; i_enable = nen;
        hit = en_m && act && x >= px_m && x < px_m + 20 && y >= py_m && y < py_m + 20;
        a = hit ? (y - py_m) * 20 + (x - px_m) : 0;
        p3 = p2; h3 = h2; p2 = p1; h2 = h1;
        p1 = hit ? rom[a] : 8'h00;
        h1 = hit && rom[a] != 8'h00;
        a1 = a;
        if (fs) begin px_m = npx; py_m = npy; en_m = nen; end
    endtask

    task automatic scan(input int x, input int y);
        cycle(x, y, 1, 0, 0, 0, 0);
    endtask

    task automatic frame(input int npx, input int npy, input bit nen);
        cycle(0, 0, 0, 1, npx, npy, nen);
    endtask

    task automatic flush();
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_midline();
        #2;
        i_rst_n = 1'b0;
        i_frame_start = 1'b0;
        #1;
        chk("rst_addr",  o_numberaddr, 0);
        chk("rst_pixel", o_pixel, 0);
        chk("rst_hit",   o_hit, 0);
        clear_model();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        rom[43] = 8'hA5; rom[0] = 8'h3C; rom[399] = 8'h77;
        rom[21] = 8'h00; rom[22] = 8'h01;
        clear_model();
        i_rst_n = 1'b0; i_x = 0; i_y = 0; i_active = 0; i_frame_start = 0;
        i_pos_x = 0; i_pos_y = 0; i_enable = 0;
        repeat (3) @(negedge i_clk);
        chk("reset_addr",  o_numberaddr, 0);
        chk("reset_pixel", o_pixel, 0);
        chk("reset_hit",   o_hit, 0);
        i_rst_n = 1'b1;

        frame(100, 50, 1);
        scan(103, 52);
        flush();
        scan(100, 50); scan(119, 69); scan(120, 50); scan(99, 50); scan(100, 70);
        scan(101, 51); scan(102, 51);
        flush();

        frame(630, 470, 1);
        for (int x = 620; x < 640; x++) scan(x, 475);
        for (int y = 460; y < 480; y++) scan(635, y);
        scan(0, 475); scan(635, 0); scan(0, 0);
        flush();

        frame(100, 50, 1);
        cycle(105, 55, 1, 0, 200, 50, 1);
        cycle(205, 55, 1, 0, 200, 50, 1);
        frame(200, 50, 1);
        scan(105, 55); scan(205, 55); scan(200, 50); scan(219, 50); scan(220, 50);
        cycle(210, 55, 1, 1, 300, 60, 1);
        scan(210, 55); scan(305, 65);
        frame(200, 50, 0);
        scan(205, 55); scan(210, 60);
        flush();

        frame(100, 50, 1);
        scan(100, 50); scan(101, 50); scan(102, 50);
        reset_midline();
        for (int i = 0; i < 5; i++) scan(100 + i, 50);
        frame(100, 50, 1);
        scan(100, 50); scan(104, 53);
        flush();

        for (int f = 0; f < 12; f++) begin
            int npx, npy, x, y;
            npx = $urandom_range(0, 639);
            npy = $urandom_range(0, 479);
            frame(npx, npy, $urandom_range(0, 3) != 0);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    x = $urandom_range(0, 639);
                    y = $urandom_range(0, 479);
                end else begin
                    x = px_m + $urandom_range(0, 24) - 2;
                    y = py_m + $urandom_range(0, 24) - 2;
                    if (x < 0) x = 0;
                    if (x > 639) x = 639;
                    if (y < 0) y = 0;
                    if (y > 479) y = 479;
                end
                cycle(x, y, $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 3) != 0);
            end
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
